// File: rtl/hex_display_arbiter.sv
// Arbitrates two requesters (software PIO, keycode monitor) for the hex display.
// Owners keep the display for at least HOLD_CYCLES before a contender can take it.
module hex_display_arbiter #(
   parameter int unsigned HOLD_CYCLES = 25_000_000
) (
   input  logic        Clk,
   input  logic        Reset_h,
   input  logic [1:0]  req,
   input  logic [19:0] data0,
   input  logic [19:0] data1,
   output logic [1:0]  gnt,
   output logic [15:0] hex_digits,
   output logic [1:0]  signs,
   output logic [1:0]  hundreds,
   output logic        owner,
   output logic        active
);

   localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);
   localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_OWN    = 2'd1;
   localparam logic [1:0] S_LINGER = 2'd2;

   logic [1:0]    state, state_n;
   logic [CW-1:0] hold_cnt, cnt_n;
   logic          last_owner, last_n;
   logic          owner_n;
   logic [1:0]    gnt_n;
   logic          load;
   logic          sat;
   logic          other;
   logic          pick;
   logic [CW-1:0] cnt_inc;
   logic [19:0]   payload;

   function automatic logic [1:0] onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

   assign sat     = (hold_cnt == HOLD_MAX);
   assign other   = ~owner;
   assign cnt_inc = sat ? hold_cnt : hold_cnt + CW'(1);
   assign payload = owner ? data1 : data0;
   assign pick    = (req == 2'b11) ? ~last_owner : req[1];
   assign active  = (state != S_IDLE);

   // Next-state, next-owner and grant decisions.
   always_comb begin
      state_n = state;
      owner_n = owner;
      last_n  = last_owner;
      cnt_n   = hold_cnt;
      gnt_n   = 2'b00;
      load    = 1'b0;
      case (state)
         S_IDLE: begin
            if (req != 2'b00) begin
               state_n = S_OWN;
               owner_n = pick;
               last_n  = pick;
               cnt_n   = '0;
               gnt_n   = onehot(pick);
            end
         end
         S_OWN: begin
            load  = 1'b1;
            cnt_n = cnt_inc;
            gnt_n = onehot(owner);
            if (!req[owner]) begin
               gnt_n   = 2'b00;
               state_n = sat ? S_IDLE : S_LINGER;
            end else if (req[other] && sat) begin
               owner_n = other;
               last_n  = other;
               cnt_n   = '0;
               gnt_n   = onehot(other);
            end
         end
         S_LINGER: begin
            cnt_n = cnt_inc;
            if (req[owner]) begin
               state_n = S_OWN;
               gnt_n   = onehot(owner);
            end else if (sat) begin
               state_n = S_IDLE;
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   // Control state registers.
   always_ff @(posedge Clk) begin
      if (Reset_h) begin
         state      <= S_IDLE;
         hold_cnt   <= '0;
         last_owner <= 1'b1;
         owner      <= 1'b0;
         gnt        <= 2'b00;
      end else begin
         state      <= state_n;
         hold_cnt   <= cnt_n;
         last_owner <= last_n;
         owner      <= owner_n;
         gnt        <= gnt_n;
      end
   end

   // Display registers track the owner's payload while owned, else hold.
   always_ff @(posedge Clk) begin
      if (Reset_h) begin
         hex_digits <= '0;
         signs      <= '0;
         hundreds   <= '0;
      end else if (load) begin
         hundreds   <= payload[19:18];
         signs      <= payload[17:16];
         hex_digits <= payload[15:0];
      end
   end

endmodule
